// File: rtl/lut_neuron_loader.sv
// Loadable lookup-table neuron: streams 2^IN_BITS entries into LUT RAM,
// then serves one-cycle-latency lookups with an error flag when unloaded.
module lut_neuron_loader #(
  parameter int IN_BITS  = 7,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic                s_valid,
  input  logic [OUT_BITS-1:0] s_data,
  output logic                s_ready,
  input  logic                q_valid,
  input  logic [IN_BITS-1:0]  q_addr,
  output logic                q_out_valid,
  output logic [OUT_BITS-1:0] q_data,
  output logic                q_err,
  output logic                loaded
);

  localparam int DEPTH = 1 << IN_BITS;
  localparam logic [IN_BITS-1:0] LAST_ADDR = {IN_BITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [IN_BITS-1:0]   wr_addr;
  logic [IN_BITS-1:0]   wr_addr_next;
  logic                 wr_en;
  logic [OUT_BITS-1:0]  mem [DEPTH];

  // Handshake and status are pure decodes of the registered state.
  assign s_ready = (state == LOAD);
  assign loaded  = (state == READY);

  // State and write-address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_addr <= '0;
    end else begin
      state   <= state_next;
      wr_addr <= wr_addr_next;
    end
  end

  // Next-state logic; a restart outranks any beat offered in the same cycle.
  always_comb begin
    state_next   = state;
    wr_addr_next = wr_addr;
    wr_en        = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) begin
          state_next   = LOAD;
          wr_addr_next = '0;
        end else begin
          state_next   = IDLE;
        end
      end
      LOAD: begin
        if (load_start) begin
          state_next   = LOAD;
          wr_addr_next = '0;
        end else if (s_valid) begin
          wr_en        = 1'b1;
          wr_addr_next = wr_addr + IN_BITS'(1);
          if (wr_addr == LAST_ADDR) begin
            state_next = READY;
          end else begin
            state_next = LOAD;
          end
        end else begin
          state_next   = LOAD;
        end
      end
      READY: begin
        if (load_start) begin
          state_next   = LOAD;
          wr_addr_next = '0;
        end else begin
          state_next   = READY;
        end
      end
      default: begin
        state_next   = IDLE;
        wr_addr_next = '0;
      end
    endcase
  end

  // Table storage: no reset, so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_addr] <= s_data;
    end
  end

  // Lookup pipeline; state is sampled before the edge, so a lookup that
  // coincides with the final load beat still reports an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_out_valid <= 1'b0;
      q_data      <= '0;
      q_err       <= 1'b0;
    end else if (q_valid) begin
      q_out_valid <= 1'b1;
      if (state == READY) begin
        q_data <= mem[q_addr];
        q_err  <= 1'b0;
      end else begin
        q_data <= '0;
        q_err  <= 1'b1;
      end
    end else begin
      q_out_valid <= 1'b0;
      q_data      <= '0;
      q_err       <= 1'b0;
    end
  end

endmodule
